// File: rtl/sort_16x8b_collector.sv
// Collects a stream of 8-bit elements into a padded 16-slot block for the
// 16x8b sorter. A block closes after 16 elements or on in_last. A completed
// block that cannot be handed over yet is parked in the fill buffer (HOLD)
// until the output register frees up.
module sort_16x8b_collector #(
    parameter logic [7:0] PAD_VALUE = 8'hFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [4:0]   out_count
);

    typedef enum logic {FILL, HOLD} state_t;

    state_t       state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q, out_data_d;
    logic [4:0]   out_count_q, out_count_d;
    logic [4:0]   pend_cnt_q, pend_cnt_d;
    logic [7:0]   buf_q [16];
    logic [7:0]   buf_d [16];

    logic         accept;
    logic         complete;
    logic         reg_free;
    logic [4:0]   fill_cnt;
    logic [4:0]   xfer_cnt;
    logic [127:0] xfer_data;

    // in_ready comes from state only, so out_ready never reaches it combinationally
    assign in_ready  = (state_q == FILL);
    assign accept    = in_valid && in_ready;
    assign complete  = accept && ((idx_q == 4'd15) || in_last);
    assign reg_free  = !out_valid_q || out_ready;
    assign fill_cnt  = {1'b0, idx_q} + 5'd1;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

    // Fill buffer write; the element completing a block is included so both
    // the direct and the deferred transfer see the whole block.
    always_comb begin
        buf_d = buf_q;
        if (accept) buf_d[idx_q] = in_data;
    end

    // Pack the block to transfer; slots past the count get PAD_VALUE so stale
    // buffer contents never leak out.
    always_comb begin
        xfer_cnt  = (state_q == HOLD) ? pend_cnt_q : fill_cnt;
        xfer_data = '0;
        for (int k = 0; k < 16; k++) begin
            xfer_data[8*k +: 8] = (k < int'(xfer_cnt)) ? buf_d[k] : PAD_VALUE;
        end
    end

    // Next-state and output-register control
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        pend_cnt_d  = pend_cnt_q;
        case (state_q)
            FILL: begin
                if (complete) begin
                    if (reg_free) begin
                        out_data_d  = xfer_data;
                        out_count_d = fill_cnt;
                        out_valid_d = 1'b1;
                        idx_d       = 4'd0;
                    end else begin
                        pend_cnt_d  = fill_cnt;
                        state_d     = HOLD;
                    end
                end else begin
                    if (accept) idx_d = idx_q + 4'd1;
                    if (out_valid_q && out_ready) out_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_data_d  = xfer_data;
                    out_count_d = pend_cnt_q;
                    out_valid_d = 1'b1;
                    idx_d       = 4'd0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            idx_q       <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 128'h0;
            out_count_q <= 5'd0;
            pend_cnt_q  <= 5'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            pend_cnt_q  <= pend_cnt_d;
        end
    end

    // Fill buffer storage; contents are masked by the count, so no reset
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_sort_16x8b_collector.sv
// Directed bench for sort_16x8b_collector: full blocks, flush padding,
// backpressure/HOLD, same-edge transfer, reset discard, single-element blocks.
module tb_sort_16x8b_collector;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [4:0]   out_count;

    int checks = 0;
    int errors = 0;

    sort_16x8b_collector #(.PAD_VALUE(8'hFF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    // Present one element for one edge; returns at the following negedge
    task automatic send(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", out_valid); end
        checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL rst_data got %0h exp 0", out_data); end
        checks++; if (out_count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", out_count); end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0h exp 1", in_ready); end
    endtask

    task automatic test_full_block();
        logic [127:0] exp;
        for (int i = 0; i < 16; i++) exp[8*i +: 8] = 8'(i);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got %0h exp 0", out_valid); end
            end
            send(8'(i), 1'b0);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %0h exp 1", out_valid); end
        checks++; if (out_data !== exp) begin errors++; $display("FAIL full_data got %h exp %h", out_data, exp); end
        checks++; if (out_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", out_count); end
        idle(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_clear got %0h exp 0", out_valid); end
    endtask

    task automatic test_flush();
        logic [127:0] exp;
        exp = {{104{1'b1}}, 24'h332211};
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got %0h exp 1", out_valid); end
        checks++; if (out_data !== exp) begin errors++; $display("FAIL flush_data got %h exp %h", out_data, exp); end
        checks++; if (out_count !== 5'd3) begin errors++; $display("FAIL flush_count got %0d exp 3", out_count); end
        idle(1);
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_a, exp_b;
        for (int i = 0; i < 16; i++) begin
            exp_a[8*i +: 8] = 8'h20 + 8'(i);
            exp_b[8*i +: 8] = 8'h40 + 8'(i);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b0);
        checks++; if (out_data !== exp_a) begin errors++; $display("FAIL bp_a_data got %h exp %h", out_data, exp_a); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_a_ready got %0h exp 1", in_ready); end
        for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready got %0h exp 0", in_ready); end
        idle(2);
        checks++; if (out_data !== exp_a) begin errors++; $display("FAIL bp_stable_data got %h exp %h", out_data, exp_a); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable_valid got %0h exp 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stable_ready got %0h exp 0", in_ready); end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_data !== exp_b) begin errors++; $display("FAIL bp_b_data got %h exp %h", out_data, exp_b); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_b_valid got %0h exp 1", out_valid); end
        checks++; if (out_count !== 5'd16) begin errors++; $display("FAIL bp_b_count got %0d exp 16", out_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_b_ready got %0h exp 1", in_ready); end
        out_ready = 1'b1;
        idle(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0h exp 0", out_valid); end
    endtask

    task automatic test_simultaneous();
        logic [127:0] exp;
        exp = {{104{1'b1}}, 24'h636261};
        out_ready = 1'b0;
        send(8'h51, 1'b0);
        send(8'h52, 1'b1);
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sim_ready_pre got %0h exp 1", in_ready); end
        out_ready = 1'b1;
        send(8'h63, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sim_valid got %0h exp 1", out_valid); end
        checks++; if (out_data !== exp) begin errors++; $display("FAIL sim_data got %h exp %h", out_data, exp); end
        checks++; if (out_count !== 5'd3) begin errors++; $display("FAIL sim_count got %0d exp 3", out_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sim_ready_post got %0h exp 1", in_ready); end
        idle(1);
    endtask

    task automatic test_reset_mid();
        int blocks;
        blocks = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(8'h90 + 8'(i), 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0h exp 0", out_valid); end
        checks++; if (out_count !== 5'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", out_count); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(8'hA5, 1'b0);
            if (out_valid === 1'b1) blocks++;
        end
        checks++; if (out_data !== {16{8'hA5}}) begin errors++; $display("FAIL rmid_data got %h exp all a5", out_data); end
        checks++; if (out_count !== 5'd16) begin errors++; $display("FAIL rmid_cnt16 got %0d exp 16", out_count); end
        idle(1);
        if (out_valid === 1'b1) blocks++;
        checks++; if (blocks != 1) begin errors++; $display("FAIL rmid_blocks got %0d exp 1", blocks); end

        // reset while a block is parked in HOLD
        blocks = 0;
        out_ready = 1'b0;
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rhold_ready got %0h exp 0", in_ready); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            if (out_valid === 1'b1) blocks++;
        end
        checks++; if (blocks != 0) begin errors++; $display("FAIL rhold_blocks got %0d exp 0", blocks); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rhold_in_ready got %0h exp 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp;
        logic [7:0]   v;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            v = 8'h71 + 8'(i);
            exp = {{120{1'b1}}, v};
            send(v, 1'b1);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %0h exp 1", i, out_valid); end
            checks++; if (out_data !== exp) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, out_data, exp); end
            checks++; if (out_count !== 5'd1) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 1", i, out_count); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %0h exp 1", i, in_ready); end
        end
        idle(1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_clear got %0h exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_flush();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
